// File: rtl/program_sequencer.sv
// PC sequencer: IDLE/RUN/DONE control, sequential or branch advance on nextIns, saturating retire count.
// Optional SEQ_WATCHDOG_EN builds a no-progress watchdog that forces DONE and raises timeout.
module program_sequencer #(
  parameter int              PC_W        = 10,
  parameter logic [PC_W-1:0] START_ADDR  = '0,
  parameter logic [PC_W-1:0] LAST_ADDR   = '1,
  parameter int              CNT_W       = 16,
  parameter int              WDOG_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             nextIns,
  input  logic             branchTaken,
  input  logic [PC_W-1:0]  branchTarget,
  input  logic             haltReq,
  output logic [PC_W-1:0]  pc,
  output logic             fetchEn,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] insCount,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_q, fetch_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

`ifdef SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    fetch_d   = 1'b0;
    timeout_d = timeout_q;
`ifdef SEQ_WATCHDOG_EN
    wdog_d    = wdog_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = START_ADDR;
          cnt_d     = '0;
          fetch_d   = 1'b1;
          timeout_d = 1'b0;
`ifdef SEQ_WATCHDOG_EN
          wdog_d    = '0;
`endif
        end
      end
      RUN: begin
        if (nextIns) begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
`ifdef SEQ_WATCHDOG_EN
          wdog_d = '0;
`endif
          if (haltReq) begin
            state_d = DONE;
          end else if (pc_q == LAST_ADDR && !branchTaken) begin
            state_d = DONE;
          end else if (branchTaken) begin
            pc_d    = branchTarget;
            fetch_d = 1'b1;
          end else begin
            pc_d    = pc_q + 1'b1;
            fetch_d = 1'b1;
          end
        end
`ifdef SEQ_WATCHDOG_EN
        // Firing on the count that would reach WDOG_CYCLES keeps the limit in cycles, not cycles+1.
        else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          wdog_d    = WDOG_W'(WDOG_CYCLES);
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= START_ADDR;
      cnt_q     <= '0;
      fetch_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      fetch_q   <= fetch_d;
      running_q <= running_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign pc       = pc_q;
  assign fetchEn  = fetch_q;
  assign running  = running_q;
  assign done     = done_q;
  assign insCount = cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed-vector bench for program_sequencer (LAST_ADDR=7, CNT_W=4 so end-of-program and saturation are reachable).
module tb_program_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       nextIns = 1'b0;
  logic       branchTaken = 1'b0;
  logic [9:0] branchTarget = '0;
  logic       haltReq = 1'b0;
  logic [9:0] pc;
  logic       fetchEn, running, done, timeout;
  logic [3:0] insCount;

  int n_vec = 0;
  int n_err = 0;
  int fetch_cnt = 0;
  int fc0;

  program_sequencer #(
    .PC_W(10), .START_ADDR(10'd0), .LAST_ADDR(10'd7), .CNT_W(4), .WDOG_CYCLES(64)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .nextIns(nextIns),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .haltReq(haltReq),
    .pc(pc), .fetchEn(fetchEn), .running(running), .done(done),
    .insCount(insCount), .timeout(timeout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (fetchEn === 1'b1) fetch_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ins(input logic br, input logic [9:0] tgt, input logic hlt);
    nextIns = 1'b1; branchTaken = br; branchTarget = tgt; haltReq = hlt;
    tick();
    nextIns = 1'b0; branchTaken = 1'b0; haltReq = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_pc", pc, 0);
    check("rst_cnt", insCount, 0);
    check("rst_flags", {fetchEn, running, done, timeout}, 4'b0000);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Run A: four sequential retires, then halt
    fc0 = fetch_cnt;
    start_run();
    check("A_start_pc", pc, 0);
    check("A_start_flags", {fetchEn, running, done}, 3'b110);
    for (int i = 1; i <= 4; i++) begin
      ins(1'b0, 10'd0, 1'b0);
      check($sformatf("A_seq%0d_pc", i), pc, i);
      check($sformatf("A_seq%0d_fe", i), fetchEn, 1);
    end
    check("A_cnt", insCount, 4);
    tick();
    check("A_fe_idle", fetchEn, 0);
    check("A_fetch_pulses", fetch_cnt - fc0, 5);
    ins(1'b0, 10'd0, 1'b1);
    check("A_halt_flags", {fetchEn, running, done}, 3'b001);
    check("A_halt_pc", pc, 4);
    check("A_halt_cnt", insCount, 5);

    // Run B: branch to 0x2A0, then halt with branchTaken also set
    start_run();
    check("B_restart_flags", {fetchEn, running, done}, 3'b110);
    check("B_restart_cnt", insCount, 0);
    repeat (3) ins(1'b0, 10'd0, 1'b0);
    check("B_pc3", pc, 3);
    ins(1'b1, 10'h2A0, 1'b0);
    check("B_br_pc", pc, 10'h2A0);
    check("B_br_fe", fetchEn, 1);
    ins(1'b1, 10'h155, 1'b1);
    check("B_halt_pc", pc, 10'h2A0);
    check("B_halt_done", done, 1);
    check("B_halt_cnt", insCount, 5);

    // Run C: sequential past LAST_ADDR ends the program
    start_run();
    repeat (7) ins(1'b0, 10'd0, 1'b0);
    check("C_pc7", pc, 7);
    check("C_running7", running, 1);
    ins(1'b0, 10'd0, 1'b0);
    check("C_end_flags", {fetchEn, running, done}, 3'b001);
    check("C_end_pc", pc, 7);
    check("C_end_cnt", insCount, 8);

    // Run D: branch from LAST_ADDR stays in RUN; wrap past all-ones; start ignored in RUN
    start_run();
    repeat (7) ins(1'b0, 10'd0, 1'b0);
    ins(1'b1, 10'd2, 1'b0);
    check("D_br_last_pc", pc, 2);
    check("D_br_last_run", {running, done}, 2'b10);
    check("D_br_last_cnt", insCount, 8);
    ins(1'b1, 10'h3FF, 1'b0);
    ins(1'b0, 10'd0, 1'b0);
    check("D_wrap_pc", pc, 0);
    check("D_wrap_cnt", insCount, 10);
    start = 1'b1;
    tick(); tick();
    check("D_start_in_run_pc", pc, 0);
    check("D_start_in_run_cnt", insCount, 10);
    check("D_start_in_run_flags", {fetchEn, running}, 2'b01);
    start = 1'b0;
    ins(1'b0, 10'd0, 1'b1);
    check("D_halt_done", done, 1);

    // DONE ignores nextIns; start restarts on the sampling edge
    ins(1'b1, 10'h123, 1'b0);
    tick();
    check("E_done_hold_pc", pc, 0);
    check("E_done_hold_cnt", insCount, 11);
    check("E_done_hold_flags", {fetchEn, running, done}, 3'b001);
    start_run();
    check("E_restart_pc", pc, 0);
    check("E_restart_cnt", insCount, 0);
    check("E_restart_flags", {fetchEn, running, done}, 3'b110);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) ins(1'b1, 10'h100, 1'b0);
    check("E_sat_cnt", insCount, 15);
    check("E_sat_pc", pc, 10'h100);

    // Asynchronous reset mid-run, away from any clock edge
    #2 reset = 1'b1;
    #1;
    check("R_async_pc", pc, 0);
    check("R_async_cnt", insCount, 0);
    check("R_async_flags", {fetchEn, running, done, timeout}, 4'b0000);
    tick();
    reset = 1'b0;
    tick();

    // Watchdog behaviour with no nextIns
    start_run();
`ifdef SEQ_WATCHDOG_EN
    repeat (63) tick();
    check("W_before_limit", {running, done, timeout}, 3'b100);
    tick();
    check("W_fired", {running, done, timeout}, 3'b011);
    check("W_pc", pc, 0);
    start_run();
    check("W_clear", {running, done, timeout}, 3'b100);
`else
    repeat (200) tick();
    check("W_no_wdog", {running, done, timeout}, 3'b100);
    check("W_no_wdog_pc", pc, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
